// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rv32_pkg                                                  |
// | Purpose  : Shared types and constants for the RV32 pipeline control  |
// |            slice (state encoding, per-stage enable bundle).          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rv32_pkg;

  localparam int unsigned MAX_FLUSH_CYCLES = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_BUSY  = 2'd2,
    FLUSH    = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic if_en;
    logic id_en;
    logic ex_en;
    logic mem_en;
    logic wb_en;
  } stage_en_t;

  // Same enable value for every stage.
  function automatic stage_en_t stage_all(input logic v);
    return stage_en_t'({5{v}});
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_perf_cnt                                             |
// | Purpose  : Free-running 32-bit performance counters for stalled      |
// |            fetch cycles and redirect events. Wraps at 2^32.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pipe_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        redirect_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Next-count: plain increment, natural wrap from all-ones to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall_i    ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (redirect_i ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipeline_ctrl                                             |
// | Purpose  : Stall/flush sequencer for the 5-stage RV32 pipeline.      |
// |            Merges trap, branch, dmem wait, mul/div busy and load-use |
// |            into per-stage advance enables and bubble strobes.        |
// |            Optional: RV32_PERF_CNT_EN adds stall/redirect counters.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pipeline_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_use_i,
  input  logic        branch_taken_i,
  input  logic        trap_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  input  logic        md_start_i,
  input  logic        md_done_i,
  output logic        if_en_o,
  output logic        id_en_o,
  output logic        ex_en_o,
  output logic        mem_en_o,
  output logic        wb_en_o,
  output logic        id_flush_o,
  output logic        ex_flush_o,
  output logic        mem_flush_o,
  output logic        redirect_o,
  output logic        md_kill_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  // Number of FLUSH-state cycles following the redirect cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO_LIMIT    = 8'(MEM_TIMEOUT);

  pipe_state_e state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [2:0]  fl_q, fl_d;

  stage_en_t   en;
  logic        id_fl, ex_fl, mem_fl, redir, kill, err;
  logic        mem_stall;
  logic [7:0]  tmo_inc;

  assign mem_stall = dmem_req_i & ~dmem_ready_i;
  assign tmo_inc   = tmo_q + 8'd1;

  // Next-state and same-cycle control outputs.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    fl_d    = fl_q;
    en      = stage_all(1'b1);
    id_fl   = 1'b0;
    ex_fl   = 1'b0;
    mem_fl  = 1'b0;
    redir   = 1'b0;
    kill    = 1'b0;
    err     = 1'b0;

    if (trap_i) begin
      // Trap beats everything, including an outstanding memory wait.
      redir  = 1'b1;
      id_fl  = 1'b1;
      ex_fl  = 1'b1;
      mem_fl = 1'b1;
      kill   = (state_q == MD_BUSY);
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fl_d    = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == MEM_WAIT && !dmem_ready_i) begin
      // Full freeze; timeout counter saturates so the error fires once.
      en = stage_all(1'b0);
      if (tmo_q != TMO_LIMIT) begin
        tmo_d = tmo_inc;
        err   = (tmo_inc == TMO_LIMIT);
      end
    end else if (state_q == MD_BUSY) begin
      // Load-use is not evaluated here; the hazard detector re-asserts after release.
      if (md_done_i) begin
        state_d = RUN;
      end else begin
        en.if_en = 1'b0;
        en.id_en = 1'b0;
        en.ex_en = 1'b0;
      end
    end else if (state_q == FLUSH) begin
      if (mem_stall) begin
        // An older access in MEM still freezes everything; flush count is held.
        en = stage_all(1'b0);
      end else if (branch_taken_i) begin
        redir = 1'b1;
        id_fl = 1'b1;
        ex_fl = 1'b1;
        fl_d  = FLUSH_RELOAD;
      end else begin
        id_fl = 1'b1;
        if (fl_q <= 3'd1) begin
          state_d = RUN;
        end else begin
          fl_d = fl_q - 3'd1;
        end
      end
    end else begin
      // RUN, or MEM_WAIT releasing this cycle: a branch held in EX during the
      // freeze is acted on here.
      state_d = RUN;
      if (mem_stall) begin
        en      = stage_all(1'b0);
        state_d = MEM_WAIT;
        tmo_d   = '0;
      end else if (branch_taken_i) begin
        redir = 1'b1;
        id_fl = 1'b1;
        ex_fl = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fl_d    = FLUSH_RELOAD;
        end
      end else if (md_start_i && !md_done_i) begin
        // EX holds the mul/div op; MEM/WB drain, so MEM receives a bubble.
        en.if_en = 1'b0;
        en.id_en = 1'b0;
        en.ex_en = 1'b0;
        state_d  = MD_BUSY;
      end else if (load_use_i) begin
        en.if_en = 1'b0;
        en.id_en = 1'b0;
        ex_fl    = 1'b1;
      end
    end
  end

  // State, timeout and flush-length registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      tmo_q   <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      fl_q    <= fl_d;
    end
  end

  // Outputs are forced inactive while reset is asserted.
  assign if_en_o     = rst_ni & en.if_en;
  assign id_en_o     = rst_ni & en.id_en;
  assign ex_en_o     = rst_ni & en.ex_en;
  assign mem_en_o    = rst_ni & en.mem_en;
  assign wb_en_o     = rst_ni & en.wb_en;
  assign id_flush_o  = rst_ni & id_fl;
  assign ex_flush_o  = rst_ni & ex_fl;
  assign mem_flush_o = rst_ni & mem_fl;
  assign redirect_o  = rst_ni & redir;
  assign md_kill_o   = rst_ni & kill;
  assign bus_err_o   = rst_ni & err;

`ifdef RV32_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .stall_i     (rst_ni & ~if_en_o),
    .redirect_i  (redirect_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire
